serial_word_loader: RTL

//   Upstream feeder for the 5-bit SR-latch word store.

---
 rtl/serial_word_loader_if.sv | 29 ++
 rtl/serial_word_loader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader_if.sv
// serial_word_loader_if
//   Bundles the serial input side and the store write side of the loader.
//   master : the feeder/consumer environment (drives sin, sin_vld, addr).
//   slave  : the loader itself (drives rdy, wr_en, wr_sel, wr_data, done, err).
//   Parameters WORD_W / ADDR_W must match the loader instance.
interface serial_word_loader_if #(
  parameter int WORD_W = 5,
  parameter int ADDR_W = 2
);
  logic                     sin;
  logic                     sin_vld;
  logic [ADDR_W-1:0]        addr;
  logic                     rdy;
  logic                     wr_en;
  logic [(1<<ADDR_W)-1:0]   wr_sel;
  logic [WORD_W-1:0]        wr_data;
  logic                     done;
  logic                     err;

  modport master (
    output sin, sin_vld, addr,
    input  rdy, wr_en, wr_sel, wr_data, done, err
  );

  modport slave (
    input  sin, sin_vld, addr,
    output rdy, wr_en, wr_sel, wr_data, done, err
  );
endinterface

// File: rtl/serial_word_loader.sv
// serial_word_loader
//   Collects a WORD_W-bit word bit-serially (LSB first) together with a word
//   address captured on the first bit, then drives a WR_PULSE-cycle write
//   strobe with a one-hot word select and a stable parallel data word, and
//   finally pulses done. All outputs are registered.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears all outputs at once)
//   bus    : serial_word_loader_if.slave
//            sin/sin_vld/addr in, rdy/wr_en/wr_sel/wr_data/done/err out
// Configuration
//   PARITY_LD_EN : when defined, a trailing even-parity bit is collected
//                  after the data bits; a bad parity gives an err pulse and
//                  no write. When undefined, err is tied to 0.
module serial_word_loader #(
  parameter int WORD_W   = 5,
  parameter int ADDR_W   = 2,
  parameter int WR_PULSE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_word_loader_if.slave  bus
);

  localparam int NSEL = 1 << ADDR_W;
  localparam int CW   = $clog2(WORD_W + 1);
  localparam int PW   = $clog2(WR_PULSE + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, WRITE, DONE
`ifdef PARITY_LD_EN
    , PAR, ERR
`endif
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     pcnt;
  logic [WORD_W-1:0] shreg;
  logic [ADDR_W-1:0] addr_q;

  logic              rdy_q;
  logic              wr_en_q;
  logic [NSEL-1:0]   wr_sel_q;
  logic [WORD_W-1:0] wr_data_q;
  logic              done_q;

  logic              accept;
  logic              last;
  logic [WORD_W-1:0] word_nxt;
  logic [NSEL-1:0]   sel_nxt;

  assign accept = bus.sin_vld & rdy_q;
  assign last   = (cnt == CW'(WORD_W - 1));

  // Word as it will look once the bit on sin lands at position cnt; lets the
  // final bit go straight into wr_data without an extra cycle.
  always_comb begin
    word_nxt = shreg;
    for (int i = 0; i < WORD_W; i++)
      if (cnt == CW'(i)) word_nxt[i] = bus.sin;
  end

  // In IDLE the address is not latched yet, so a 1-bit word must use the
  // live addr input.
  assign sel_nxt = NSEL'(1) << ((state == IDLE) ? bus.addr : addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pcnt      <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, SHIFT: begin
          rdy_q <= 1'b1;
          if (accept) begin
            shreg <= word_nxt;
            if (state == IDLE) addr_q <= bus.addr;
            if (last) begin
              cnt <= '0;
`ifdef PARITY_LD_EN
              state <= PAR;
`else
              state     <= WRITE;
              rdy_q     <= 1'b0;
              wr_en_q   <= 1'b1;
              wr_sel_q  <= sel_nxt;
              wr_data_q <= word_nxt;
              pcnt      <= '0;
`endif
            end else begin
              cnt   <= cnt + CW'(1);
              state <= SHIFT;
            end
          end
        end
`ifdef PARITY_LD_EN
        PAR: begin
          if (accept) begin
            rdy_q <= 1'b0;
            if ((^shreg) ^ bus.sin) begin
              state <= ERR;
            end else begin
              state     <= WRITE;
              wr_en_q   <= 1'b1;
              wr_sel_q  <= sel_nxt;
              wr_data_q <= shreg;
              pcnt      <= '0;
            end
          end
        end
        ERR: begin
          rdy_q <= 1'b1;
          state <= IDLE;
        end
`endif
        WRITE: begin
          if (pcnt == PW'(WR_PULSE - 1)) begin
            wr_en_q  <= 1'b0;
            wr_sel_q <= '0;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        DONE: begin
          rdy_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARITY_LD_EN
  logic err_q;
  // err is high exactly while in ERR, which lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state == PAR) && accept && ((^shreg) ^ bus.sin);
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rdy     = rdy_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_sel  = wr_sel_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;

endmodule
